dffram_wb_bridge: RTL and testbench
===================================

DFFRAM_WB_BRIDGE -- requirements
Module: dffram_wb_bridge

Interface
REQ-001 Parameter: BASE_ADDR, default 32'h0000_0000, byte base of the 1 KB RAM window; only bits [31:10] are significant.
REQ-002 wb_clk_i  input  1  single clock for all logic; rising-edge.
REQ-003 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-004 wbs_cyc_i  input  1  Wishbone cycle valid.
REQ-005 wbs_stb_i  input  1  Wishbone strobe.
REQ-006 wbs_we_i  input  1  1 = write, 0 = read.
REQ-007 wbs_sel_i  input  4  byte lane select; bit n covers data[8n+7:8n].
REQ-008 wbs_adr_i  input  32  byte address.
REQ-009 wbs_dat_i  input  32  write data.
REQ-010 wbs_dat_o  output  32  read data, registered.
REQ-011 wbs_ack_o  output  1  transfer acknowledge, registered.
REQ-012 wbs_err_o  output  1  transfer error, registered.
REQ-013 ram_en_o  output  1  RAM port enable.
REQ-014 ram_we_o  output  4  RAM byte write enables.
REQ-015 ram_a_o  output  8  RAM word address.
REQ-016 ram_di_o  output  32  RAM write data.
REQ-017 ram_do_i  input  32  RAM read data; valid the cycle after the edge that sampled ram_en_o=1.

Function
REQ-018 Request = wbs_cyc_i & wbs_stb_i; hit = (wbs_adr_i[31:10] == BASE_ADDR[31:10]); word index = wbs_adr_i[9:2]; wbs_adr_i[1:0] ignored.
REQ-019 FSM states: IDLE, RD_WAIT, RESP; reset state IDLE.
REQ-020 RAM drive is combinational and active only in IDLE with request & hit: ram_en_o=1, ram_a_o=word index, ram_di_o=wbs_dat_i, ram_we_o = wbs_we_i ? wbs_sel_i : 4'b0000.
REQ-021 In every other case ram_en_o=0 and ram_we_o=0; ram_a_o/ram_di_o still follow wbs_adr_i[9:2]/wbs_dat_i.
REQ-022 IDLE, request & hit & write: RAM written at that edge; go RESP with wbs_ack_o=1 -> ack visible 1 cycle after request (1 wait state).
REQ-023 IDLE, request & hit & read: go RD_WAIT; RD_WAIT: if wbs_cyc_i=1, capture ram_do_i into wbs_dat_o, set wbs_ack_o=1, go RESP -> ack 2 cycles after request.
REQ-024 IDLE, request & miss: no RAM access; go RESP with wbs_err_o=1, wbs_ack_o=0, wbs_dat_o unchanged.
REQ-025 RESP lasts exactly one cycle: wbs_ack_o/wbs_err_o cleared at next edge, state returns IDLE; no new request accepted in RESP (a held strobe is re-served from IDLE on the following cycle).
REQ-026 Abort: wbs_cyc_i=0 in RD_WAIT -> IDLE, no ack, wbs_dat_o unchanged; writes already issued are not undone.
REQ-027 Write with wbs_sel_i=4'b0000: enable pulses with no byte written; ack returned normally.
REQ-028 Read ignores wbs_sel_i; full 32-bit word returned.
REQ-029 wbs_ack_o and wbs_err_o never high in the same cycle; at most one of them per request.
REQ-030 wbs_dat_o holds its last captured value between reads.
REQ-031 Address 0x3FC offset maps to word 255; no wrap beyond the window (higher bits decide hit).

Reset
REQ-032 While wb_rst_i=1: state IDLE, wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=32'h0, ram_en_o=0, ram_we_o=4'b0000.
REQ-033 Reset asserted mid-transfer (RD_WAIT or RESP) aborts immediately; no ack after release; RAM contents are not reset by this block.
REQ-034 First request is accepted on the first rising edge after wb_rst_i deasserts.

Verification
REQ-035 BASE_ADDR=0x3000_0000; write 0x3000_0010 data 0xDEADBEEF sel 4'hF -> ram_we_o=4'hF, ram_a_o=8'h04 for 1 cycle; ack 1 cycle later; read same address -> ack 2 cycles after request, wbs_dat_o=0xDEADBEEF.
REQ-036 Write 0x3000_0010 data 0x11223344 sel 4'b0101 over 0xDEADBEEF -> read returns 0xDE22BE44.
REQ-037 Access 0x3000_0400 (miss) -> wbs_err_o=1 for 1 cycle, wbs_ack_o=0, ram_en_o never asserted.
REQ-038 Read issued then wbs_cyc_i dropped in RD_WAIT -> no ack, FSM IDLE next cycle, wbs_dat_o unchanged.
REQ-039 wb_rst_i pulsed asynchronously during RD_WAIT -> all outputs zero immediately; no ack after release; following write/read pair completes normally.
REQ-040 Back-to-back reads of words 0..255 with strobe held -> each acked exactly once, 3-cycle spacing, data matches model.

Source files
------------

// File: rtl/dffram_wb_bridge.sv
// Wishbone classic slave bridging a 1 KB window onto a 256x32 DFF RAM macro.
// Writes ack after one wait state, reads after two; misses return err.
module dffram_wb_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        ram_en_o,
  output logic [3:0]  ram_we_o,
  output logic [7:0]  ram_a_o,
  output logic [31:0] ram_di_o,
  input  logic [31:0] ram_do_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic req;
  logic hit;
  logic acc;
  logic ack_d;
  logic err_d;
  logic dat_ld;
  logic unused_adr;

  assign req = wbs_cyc_i & wbs_stb_i;
  assign hit = (wbs_adr_i[31:10] == BASE_ADDR[31:10]);
  assign unused_adr = &{1'b0, wbs_adr_i[1:0]};

  // RAM is touched only from IDLE; reset masks a request held through it
  assign acc      = ~wb_rst_i & (state_q == IDLE) & req & hit;
  assign ram_en_o = acc;
  assign ram_we_o = (acc & wbs_we_i) ? wbs_sel_i : 4'b0000;
  assign ram_a_o  = wbs_adr_i[9:2];
  assign ram_di_o = wbs_dat_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = (hit & ~wbs_we_i) ? RD_WAIT : RESP;
        end
      end
      RD_WAIT: state_d = wbs_cyc_i ? RESP : IDLE;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d  = 1'b0;
    err_d  = 1'b0;
    dat_ld = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          err_d = ~hit;
          ack_d = hit & wbs_we_i;
        end
      end
      RD_WAIT: begin
        ack_d  = wbs_cyc_i;
        dat_ld = wbs_cyc_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= 32'h0;
    end else begin
      wbs_ack_o <= ack_d;
      wbs_err_o <= err_d;
      if (dat_ld) begin
        wbs_dat_o <= ram_do_i;
      end
    end
  end

endmodule

// File: tb/tb_dffram_wb_bridge.sv
// Random and directed Wishbone traffic against a word-array memory model;
// a behavioural RAM macro sits on the RAM port.
module tb_dffram_wb_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [7:0]  ram_a;
  logic [31:0] ram_di;
  logic [31:0] ram_do;

  logic [31:0] ram     [256];
  logic [31:0] ref_mem [256];
  logic        init_req;
  logic [31:0] last_dat;
  int          n_tests;
  int          n_fail;
  int          both_hi;

  dffram_wb_bridge #(.BASE_ADDR(BASE)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_w),
    .wbs_dat_o (dat_r),
    .wbs_ack_o (ack),
    .wbs_err_o (err),
    .ram_en_o  (ram_en),
    .ram_we_o  (ram_we),
    .ram_a_o   (ram_a),
    .ram_di_o  (ram_di),
    .ram_do_i  (ram_do)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM macro: synchronous read, byte-masked write
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 256; i++) ram[i] <= ref_mem[i];
    end else if (ram_en) begin
      ram_do <= ram[ram_a];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
    end
  end

  always @(negedge clk) begin
    if (ack && err) both_hi++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    logic        h;
    logic [7:0]  w;
    logic [31:0] exp_rd;
    int          lat;
    int          n;
    h = ((a >> 10) == (BASE >> 10));
    w = a[9:2];
    exp_rd = ref_mem[w];
    lat = (h && !wr) ? 2 : 1;
    cyc = 1'b1; stb = 1'b1; we = wr; adr = a; dat_w = d; sel = s;
    @(negedge clk);
    check("ram_en", {31'b0, ram_en}, {31'b0, h});
    if (h) begin
      check("ram_a", {24'b0, ram_a}, {24'b0, w});
      check("ram_we", {28'b0, ram_we}, wr ? {28'b0, s} : 32'h0);
      if (wr) check("ram_di", ram_di, d);
    end
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) check("en_1cyc", {31'b0, ram_en}, 32'h0);
    end while (!ack && !err && n < 6);
    check("latency", n, lat);
    check("ack", {31'b0, ack}, {31'b0, h});
    check("err", {31'b0, err}, {31'b0, !h});
    if (h && wr) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    end
    if (h && !wr) last_dat = exp_rd;
    check("dat", dat_r, last_dat);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("resp_1cyc", {30'b0, ack, err}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int cnt;
    int prev;
    int idx;
    n_tests = 0; n_fail = 0; both_hi = 0;
    last_dat = 32'h0;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    sel = 4'h0; adr = 32'h0; dat_w = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    init_req = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    init_req = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE;
    #1;
    check("rst_ram_en", {31'b0, ram_en}, 32'h0);
    check("rst_ram_we", {28'b0, ram_we}, 32'h0);
    check("rst_outs", {30'b0, ack, err}, 32'h0);
    check("rst_dat", dat_r, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // first request right after reset release
    xfer(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF);
    xfer(1'b0, 32'h3000_0010, 32'h0, 4'h0);
    check("req035", dat_r, 32'hDEAD_BEEF);
    xfer(1'b1, 32'h3000_0010, 32'h1122_3344, 4'b0101);
    xfer(1'b0, 32'h3000_0010, 32'h0, 4'h0);
    check("req036", dat_r, 32'hDE22_BE44);
    xfer(1'b1, 32'h3000_0400, 32'hCAFE_F00D, 4'hF);
    xfer(1'b0, 32'h3000_0400, 32'h0, 4'hF);
    xfer(1'b1, 32'h3000_03FE, 32'hA5A5_5A5A, 4'hF);
    xfer(1'b0, 32'h3000_03FC, 32'h0, 4'h0);
    xfer(1'b1, 32'h3000_0020, 32'hFFFF_FFFF, 4'h0);
    xfer(1'b0, 32'h3000_0020, 32'h0, 4'h3);

    // abort a read in RD_WAIT
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0044;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("abort_ack", {30'b0, ack, err}, 32'h0);
    check("abort_dat", dat_r, last_dat);
    xfer(1'b1, 32'h3000_0044, 32'h0BAD_CAFE, 4'hC);

    // async reset while in RD_WAIT
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0044;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_outs", {30'b0, ack, err}, 32'h0);
    check("arst_dat", dat_r, 32'h0);
    check("arst_ram_en", {31'b0, ram_en}, 32'h0);
    last_dat = 32'h0;
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("arst_noack", {30'b0, ack, err}, 32'h0);
    xfer(1'b1, 32'h3000_0048, 32'h1357_9BDF, 4'hF);
    xfer(1'b0, 32'h3000_0048, 32'h0, 4'h0);

    // back-to-back reads of the whole window, strobe held
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE;
    cnt = 0; prev = 0; idx = 0;
    while (idx < 256 && cnt < 2000) begin
      @(posedge clk); #1;
      cnt++;
      if (ack) begin
        check("b2b_dat", dat_r, ref_mem[idx]);
        if (idx > 0) check("b2b_gap", cnt - prev, 3);
        prev = cnt;
        idx++;
        adr = BASE + 32'(idx * 4);
      end
    end
    check("b2b_count", idx, 256);
    last_dat = ref_mem[255];
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom;
        if ((a >> 10) == (BASE >> 10)) a = a ^ 32'h8000_0000;
      end else begin
        a = BASE + ($urandom & 32'h3FF);
      end
      xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
    end

    check("ack_err_excl", both_hi, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
